// File: rtl/systolic_mac_array_pkg.sv
// Shared definitions for the systolic MAC array and its upstream shifter.
//   - calc_max_dim : array dimension derived from bus and operand widths
//   - state_e      : 2-bit sequencer state encoding
//   - elem_idx     : flat index of element (i,j) in a row-major packed matrix
package systolic_mac_array_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BUS_WIDTH  = 32;

  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Row-major packing: element (i,j) sits at slot i*dim+j.
  function automatic int elem_idx(input int i, input int j, input int dim);
    return i * dim + j;
  endfunction

endpackage

// File: rtl/systolic_mac_array_if.sv
// Bus between the register layer / shifter and the systolic MAC array.
//   master : drives start, skewed operand vectors, beat qualifiers, initial C
//   slave  : the array; returns flattened C, per-PE overflow, busy and done
interface systolic_mac_array_if
  import systolic_mac_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
);
  localparam int MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);

  logic                                   start_i;
  logic [MAX_DIM*DATA_WIDTH-1:0]          in_vector_a;
  logic [MAX_DIM*DATA_WIDTH-1:0]          in_vector_b;
  logic                                   valid_i;
  logic                                   last_i;
  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   c_flat_in;
  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0]   c_flat_out;
  logic [MAX_DIM*MAX_DIM-1:0]             overflow_o;
  logic                                   busy_o;
  logic                                   done_o;

  modport master (
    output start_i, in_vector_a, in_vector_b, valid_i, last_i, c_flat_in,
    input  c_flat_out, overflow_o, busy_o, done_o
  );

  modport slave (
    input  start_i, in_vector_a, in_vector_b, valid_i, last_i, c_flat_in,
    output c_flat_out, overflow_o, busy_o, done_o
  );

endinterface

// File: rtl/systolic_mac_array_pe.sv
// One processing element of the systolic array.
//   load_i    : accumulator <- c_init_i, operand regs and overflow cleared
//   advance_i : operand regs capture a/b inputs, accumulator += a*b
//   a_o/b_o   : registered operands forwarded right / down
//   acc_o     : accumulator, ovf_o : sticky carry-out of the accumulate
module systolic_pe
  import systolic_mac_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic                  advance_i,
  input  logic [DATA_WIDTH-1:0] a_in_i,
  input  logic [DATA_WIDTH-1:0] b_in_i,
  input  logic [BUS_WIDTH-1:0]  c_init_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [BUS_WIDTH-1:0]  acc_o,
  output logic                  ovf_o
);

  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [BUS_WIDTH-1:0]    acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [BUS_WIDTH:0]      sum;

  always_comb begin
    prod  = {{DATA_WIDTH{1'b0}}, a_in_i} * {{DATA_WIDTH{1'b0}}, b_in_i};
    // One extra bit on the adder exposes the carry used for the overflow flag.
    sum   = {1'b0, acc_q} + {{(BUS_WIDTH+1-2*DATA_WIDTH){1'b0}}, prod};
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_i) begin
      a_d   = '0;
      b_d   = '0;
      acc_d = c_init_i;
      ovf_d = 1'b0;
    end else if (advance_i) begin
      a_d   = a_in_i;
      b_d   = b_in_i;
      acc_d = sum[BUS_WIDTH-1:0];
      ovf_d = ovf_q | sum[BUS_WIDTH];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/systolic_mac_array.sv
// MAX_DIM x MAX_DIM output-stationary systolic MAC array with drain sequencer.
//   clk_i, rst_n_i : clock and asynchronous active-low reset
//   bus (slave)    : start, skewed operand beats (valid/last), initial C in;
//                    flattened C out, per-PE overflow, busy, one-cycle done
// A operands move left to right, B operands top to bottom. After the last
// beat the edges are fed zeros for 2*(MAX_DIM-1) cycles so the skewed tail
// reaches the far corner before done is raised.
module systolic_mac_array
  import systolic_mac_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input logic               clk_i,
  input logic               rst_n_i,
  systolic_mac_array_if.slave bus
);

  localparam int MAX_DIM      = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int DRAIN_CYCLES = 2 * (MAX_DIM - 1);
  localparam int CNT_W        = $clog2(DRAIN_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               drain;
  logic               advance;

  assign drain   = (state_q == ST_DRAIN);
  // start_i wins over any beat presented in the same cycle.
  assign advance = ((state_q == ST_RUN) && bus.valid_i && !bus.start_i) || drain;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (bus.start_i) begin
      state_d     = ST_RUN;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN: begin
          if (bus.valid_i && bus.last_i) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
            state_d     = ST_DONE;
            drain_cnt_d = '0;
          end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;

  logic [DATA_WIDTH-1:0] a_pipe [MAX_DIM][MAX_DIM];
  logic [DATA_WIDTH-1:0] b_pipe [MAX_DIM][MAX_DIM];

  for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
    for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
      localparam int IDX = elem_idx(gi, gj, MAX_DIM);
      logic [DATA_WIDTH-1:0] a_in, b_in;
      logic [BUS_WIDTH-1:0]  acc;
      logic                  ovf;

      if (gj == 0) begin : g_a_edge
        assign a_in = drain ? '0 : bus.in_vector_a[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_a_link
        assign a_in = a_pipe[gi][gj-1];
      end

      if (gi == 0) begin : g_b_edge
        assign b_in = drain ? '0 : bus.in_vector_b[gj*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_b_link
        assign b_in = b_pipe[gi-1][gj];
      end

      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUS_WIDTH (BUS_WIDTH)
      ) u_pe (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (bus.start_i),
        .advance_i(advance),
        .a_in_i   (a_in),
        .b_in_i   (b_in),
        .c_init_i (bus.c_flat_in[IDX*BUS_WIDTH +: BUS_WIDTH]),
        .a_o      (a_pipe[gi][gj]),
        .b_o      (b_pipe[gi][gj]),
        .acc_o    (acc),
        .ovf_o    (ovf)
      );

      assign bus.c_flat_out[IDX*BUS_WIDTH +: BUS_WIDTH] = acc;
      assign bus.overflow_o[IDX]                        = ovf;
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Scoreboard bench for systolic_mac_array (DATA_WIDTH=8, BUS_WIDTH=32, 4x4).
// The driver skews A/B into beats and pushes the reference result when it
// drives the last beat; a monitor pops and compares on every done_o pulse.
module tb_systolic_mac_array;

  localparam int DW = 8;
  localparam int BW = 32;
  localparam int D  = 4;
  localparam int CW = BW * D * D;

  typedef struct {
    logic [CW-1:0]  c;
    logic [D*D-1:0] ovf;
    int unsigned    done_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int unsigned cycle_cnt;
  int n_tests;
  int n_fail;
  exp_t sb[$];
  logic [CW-1:0] last_c;

  logic [DW-1:0] a_m [D][D];
  logic [DW-1:0] b_m [D][D];
  logic [BW-1:0] c_init [D][D];

  systolic_mac_array_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

  systolic_mac_array #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned done_cyc);
    exp_t e;
    logic [BW:0] s;
    e.c = '0;
    e.ovf = '0;
    e.done_cyc = done_cyc;
    for (int i = 0; i < D; i++) begin
      for (int j = 0; j < D; j++) begin
        s = {1'b0, c_init[i][j]};
        for (int k = 0; k < D; k++) begin
          s = {1'b0, s[BW-1:0]} + (BW+1)'(a_m[i][k]) * (BW+1)'(b_m[k][j]);
          if (s[BW]) e.ovf[i*D+j] = 1'b1;
        end
        e.c[(i*D+j)*BW +: BW] = s[BW-1:0];
      end
    end
    return e;
  endfunction

  function automatic logic [CW-1:0] pack_init();
    logic [CW-1:0] v;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++)
        v[(i*D+j)*BW +: BW] = c_init[i][j];
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("c_result", bus.c_flat_out, e.c);
        chk("overflow", CW'(bus.overflow_o), CW'(e.ovf));
        chk("done_latency", CW'(cycle_cnt), CW'(e.done_cyc));
        chk("busy_at_done", CW'(bus.busy_o), 0);
        last_c = e.c;
        $display("[TB] done: cycle %0d c00=%0d", cycle_cnt, bus.c_flat_out[BW-1:0]);
      end
    end
  end

  task automatic do_start();
    logic [CW-1:0] init_v;
    init_v = pack_init();
    bus.c_flat_in = init_v;
    bus.start_i   = 1'b1;
    bus.valid_i   = 1'b1;  // beat in the start cycle must be ignored
    bus.last_i    = 1'b1;
    bus.in_vector_a = '1;
    bus.in_vector_b = '1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    chk("start_load", bus.c_flat_out, init_v);
    chk("start_ovf_clr", CW'(bus.overflow_o), 0);
    chk("start_busy", CW'(bus.busy_o), 1);
  endtask

  task automatic send_beats(input int nbeats, input int stall_at, input int stall_len,
                            input bit push_en);
    logic [D*DW-1:0] av, bv;
    for (int t = 0; t < nbeats; t++) begin
      if (t == stall_at) begin
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b1;  // last without valid must be ignored
        repeat (stall_len) @(negedge clk);
        bus.last_i  = 1'b0;
      end
      av = '0;
      bv = '0;
      for (int i = 0; i < D; i++) begin
        if (t - i >= 0 && t - i < D) begin
          av[i*DW +: DW] = a_m[i][t-i];
          bv[i*DW +: DW] = b_m[t-i][i];
        end
      end
      bus.in_vector_a = av;
      bus.in_vector_b = bv;
      bus.valid_i     = 1'b1;
      bus.last_i      = (t == nbeats - 1);
      if (t == nbeats - 1 && push_en) sb.push_back(model(cycle_cnt + 7));
      @(negedge clk);
    end
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    chk("busy_after_beats", CW'(bus.busy_o), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end else begin
      repeat (3) @(negedge clk);
      chk("hold_idle", bus.c_flat_out, last_c);
    end
  endtask

  task automatic clear_mats(input logic [BW-1:0] cval);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        a_m[i][j] = '0;
        b_m[i][j] = '0;
        c_init[i][j] = cval;
      end
  endtask

  task automatic load_identity();
    logic [DW-1:0] rows [D][D];
    rows = '{'{8'd1, 8'd2, 8'd3, 8'd4}, '{8'd5, 8'd6, 8'd7, 8'd8},
             '{8'd8, 8'd7, 8'd6, 8'd5}, '{8'd4, 8'd3, 8'd2, 8'd1}};
    clear_mats(32'd1);
    for (int i = 0; i < D; i++) begin
      a_m[i][i] = 8'd1;
      for (int j = 0; j < D; j++) b_m[i][j] = rows[i][j];
    end
  endtask

  task automatic load_random(input logic [BW-1:0] cval);
    clear_mats(cval);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        a_m[i][j] = DW'($urandom_range(255));
        b_m[i][j] = DW'($urandom_range(255));
        c_init[i][j] = cval + BW'($urandom_range(1000));
      end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cycle_cnt = 0;
    last_c = '0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    bus.in_vector_a = '0;
    bus.in_vector_b = '0;
    bus.c_flat_in   = '0;
    clear_mats(32'd0);
    repeat (3) @(negedge clk);
    chk("rst_c", bus.c_flat_out, 0);
    chk("rst_ovf", CW'(bus.overflow_o), 0);
    chk("rst_busy", CW'(bus.busy_o), 0);
    chk("rst_done", CW'(bus.done_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single beat: C(0,0)=7+3*5.
    clear_mats(32'd7);
    a_m[0][0] = 8'd3;
    b_m[0][0] = 8'd5;
    do_start();
    send_beats(1, -1, 0, 1'b1);
    wait_idle();
    $display("[TB] single beat checked");

    // Identity A, skewed over 7 beats.
    load_identity();
    do_start();
    send_beats(7, -1, 0, 1'b1);
    wait_idle();
    $display("[TB] identity checked");

    // Same with a 3-cycle stall after beat 2.
    load_identity();
    do_start();
    send_beats(7, 3, 3, 1'b1);
    wait_idle();
    $display("[TB] stall checked");

    // Wrap: 0xFFFFFFFF + 1*1 -> 0 with overflow.
    clear_mats(32'd0);
    c_init[0][0] = 32'hFFFF_FFFF;
    a_m[0][0] = 8'd1;
    b_m[0][0] = 8'd1;
    do_start();
    send_beats(1, -1, 0, 1'b1);
    wait_idle();
    chk("ovf_sticky", CW'(bus.overflow_o), CW'(1));
    load_random(32'd0);
    do_start();
    send_beats(7, -1, 0, 1'b1);
    wait_idle();
    $display("[TB] wrap checked");

    // Abort during DRAIN; only the second operation reports.
    load_identity();
    do_start();
    send_beats(7, -1, 0, 1'b0);
    repeat (3) @(negedge clk);
    load_random(32'd0);
    clear_mats(32'd0);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        a_m[i][j] = DW'(i + 2*j + 1);
        b_m[i][j] = DW'(3*i + j + 2);
      end
    do_start();
    send_beats(7, -1, 0, 1'b1);
    wait_idle();
    $display("[TB] abort checked");

    // Reset mid-RUN.
    load_random(32'd5);
    do_start();
    send_beats(3, -1, 0, 1'b0);
    bus.valid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_c", bus.c_flat_out, 0);
    chk("midrst_ovf", CW'(bus.overflow_o), 0);
    chk("midrst_busy", CW'(bus.busy_o), 0);
    chk("midrst_done", CW'(bus.done_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_vector_a = '1;
    bus.in_vector_b = '1;
    bus.valid_i = 1'b1;
    bus.last_i  = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid_i = 1'b0;
    bus.last_i  = 1'b0;
    chk("post_rst_c", bus.c_flat_out, 0);
    chk("post_rst_busy", CW'(bus.busy_o), 0);
    load_random(32'd100);
    do_start();
    send_beats(7, 2, 2, 1'b1);
    wait_idle();
    $display("[TB] reset checked");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_mac_array.md
Name: systolic_mac_array

Overview:
- Downstream compute stage of matrix_shifter: consumes the skewed per-cycle operand vectors (out_vector_a/out_vector_b) and accumulates C = A×B + C_init.
- MAX_DIM×MAX_DIM grid of registered MAC PEs. A operands flow left→right; B operands flow top→bottom.
- Contains its own drain sequencer; returns the flattened C matrix to the register/bus layer.

Parameters:
DATA_WIDTH, 8, operand element width (unsigned)
BUS_WIDTH, 32, accumulator/C element width
MAX_DIM, BUS_WIDTH/DATA_WIDTH (localparam), array dimension

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
start_i  in  1  load accumulators from c_flat_in, clear overflow, enter RUN
in_vector_a  in  MAX_DIM*DATA_WIDTH  element i [i*DW +: DW] enters row i, col 0
in_vector_b  in  MAX_DIM*DATA_WIDTH  element j enters col j, row 0
valid_i  in  1  operand beat valid; low = stall
last_i  in  1  qualifies final beat (only meaningful with valid_i)
c_flat_in  in  BUS_WIDTH*MAX_DIM*MAX_DIM  initial C; element (i,j) at [(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH]
c_flat_out  out  BUS_WIDTH*MAX_DIM*MAX_DIM  accumulator contents, same packing
overflow_o  out  MAX_DIM*MAX_DIM  sticky per-PE wrap flag, bit i*MAX_DIM+j
busy_o  out  1  high in RUN or DRAIN
done_o  out  1  one-cycle pulse when result final

Behaviour:
- Reset: all accumulators, a/b pipeline regs, overflow_o, busy_o and done_o = 0; FSM = IDLE. Asynchronous assert, synchronous release.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start_i → RUN.
  - RUN + valid_i&last_i → DRAIN.
  - DRAIN after 2*(MAX_DIM-1) cycles → DONE.
  - DONE → IDLE next cycle.
  - done_o is high only while in DONE.
- start_i is honoured in any state:
  - accumulators ← c_flat_in; a/b regs ← 0; overflow_o ← 0; drain counter ← 0; go RUN.
  - Beats presented in the start cycle are ignored.
  - start_i in RUN/DRAIN aborts the current operation; no done_o is produced for it.
- PE(i,j) inputs:
  - a_in = in_vector_a[i] if j==0, else a_reg(i,j-1).
  - b_in = in_vector_b[j] if i==0, else b_reg(i-1,j).
- Advance cycle = (RUN & valid_i & !start_i) or DRAIN. On each advance cycle:
  - a_reg ← a_in, b_reg ← b_in.
  - acc ← acc + a_in*b_in. The product is 2*DATA_WIDTH wide, zero-extended to BUS_WIDTH; the add wraps modulo 2^BUS_WIDTH.
  - A carry-out sets overflow_o for that PE (sticky until start_i).
- In DRAIN, array-edge inputs are forced to 0. valid_i/last_i are ignored outside RUN.
- Stall: RUN with valid_i=0 freezes all regs and accumulators.
- last_i without valid_i is ignored.
- Latency: done_o is high in the (2*(MAX_DIM-1)+1)th cycle after the edge that samples valid&last. This is 7 cycles for MAX_DIM=4.
- c_flat_out is combinationally driven from the accumulators. It is stable from done_o until the next start_i, and held through IDLE.
- Operand skew and zero-padding for N/K/M below MAX_DIM are the upstream shifter's job; this block is dimension-agnostic.

Decomposition:
- Shared package holds:
  - MAX_DIM derivation
  - FSM state encoding (2-bit)
  - element-index helper functions for the (i,j) flat packing, also used by matrix_shifter
- One sub-module, systolic_pe: a_reg, b_reg, accumulator, overflow, with advance/load controls. It is instantiated MAX_DIM² times by a generate loop. The top level holds the FSM and drain counter.

Test Plan:
- Single beat: c_flat_in all 7, a=(3,0,0,0), b=(5,0,0,0), valid&last in one beat → C(0,0)=22, others 7; done_o exactly 7 cycles later; busy_o high throughout.
- Identity: A=I₄, B rows {1,2,3,4},{5,6,7,8},{8,7,6,5},{4,3,2,1}, bench-skewed over 7 beats, C_init=1 → C=B+1.
- Stall: same as identity with valid_i low for 3 cycles after beat 2 → identical C; done_o 3 cycles later.
- Wrap: C_init(0,0)=32'hFFFF_FFFF, a0=b0=1 → C(0,0)=0, overflow_o[0]=1; next start_i clears it.
- Abort: start_i during DRAIN with new c_flat_in=0 → no done_o for the first operation; second operation's result is correct.
- Reset: rst_n_i pulsed mid-RUN → all outputs 0 immediately; FSM IDLE; beats ignored until start_i.
